fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, maximum in-flight plus buffered fetches (power of 2, >=2).
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 StallF_i  in  1  hazard-unit stall: issue no new fetch request.
REQ-006 StallD_i  in  1  hazard-unit stall: hold decode outputs.
REQ-007 FlushD_i  in  1  hazard-unit flush: load bubble into decode outputs.
REQ-008 PCSrcE_i  in  1  taken branch/jump redirect from execute.
REQ-009 PCTargetE_i  in  32  redirect target address.
REQ-010 IReqValid_o  out  1  instruction-memory request valid.
REQ-011 IReqReady_i  in  1  instruction memory accepts request.
REQ-012 IReqAddr_o  out  32  request address (word aligned).
REQ-013 IRspValid_i  in  1  in-order response valid, one per accepted request, >=1 cycle after acceptance.
REQ-014 IRspData_i  in  32  response instruction word.
REQ-015 InstrD_o  out  32  decode-stage instruction.
REQ-016 PCD_o  out  32  decode-stage PC.
REQ-017 PCPlus4D_o  out  32  PCD_o + 4.
REQ-018 ValidD_o  out  1  decode-stage entry is a real instruction.

Function
REQ-019 PC register SHALL drive IReqAddr_o; request accepted when IReqValid_o && IReqReady_i, then PC <= PC + 4 (mod 2^32, wrap silent).
REQ-020 IReqValid_o SHALL be 1 only when !StallF_i && !PCSrcE_i && (inflight + fifo_count) < DEPTH.
REQ-021 IReqValid_o MAY drop without acceptance; memory samples only on valid&&ready.
REQ-022 Each accepted request SHALL record its PC in an in-flight PC queue; each non-dropped response SHALL push {PC, IRspData_i} into the instruction FIFO.
REQ-023 Credit rule (REQ-020) SHALL guarantee the FIFO never overflows; response with full FIFO is a design error (assertion).
REQ-024 When !StallD_i: FlushD_i -> ValidD_o=0, InstrD_o=NOP (32'h0000_0013); else FIFO non-empty -> pop head into decode outputs, ValidD_o=1; else bubble (ValidD_o=0, NOP).
REQ-025 When StallD_i, decode outputs and FIFO head SHALL hold; StallD_i has priority over FlushD_i.
REQ-026 Latency: accept in cycle N, response in cycle M>N -> decode outputs valid from cycle M+1 earliest (FIFO empty, no stall).
REQ-027 PCSrcE_i SHALL, same edge: PC <= PCTargetE_i, FIFO cleared, drop_cnt <= inflight - (IRspValid_i ? 1 : 0), in-flight PC queue cleared.
REQ-028 Responses arriving with drop_cnt>0 SHALL be discarded, drop_cnt decremented; PCSrcE_i cycle response also discarded.
REQ-029 New requests after redirect SHALL be counted in inflight only; credit check SHALL include drop_cnt so total outstanding <= DEPTH.
REQ-030 Simultaneous FIFO push and pop SHALL keep count unchanged; simultaneous accept and response SHALL keep inflight unchanged.
REQ-031 PCTargetE_i[1:0] nonzero SHALL be forced to zero (no misaligned fetch).

Reset
REQ-032 On rst: PC=RESET_PC, FIFO/PC queue empty, inflight=0, drop_cnt=0, IReqValid_o=0, ValidD_o=0, InstrD_o=NOP, PCD_o=0, PCPlus4D_o=4.
REQ-033 rst mid-operation SHALL abandon all outstanding requests; memory interface is reset by the same rst.

Structure
REQ-034 Shared package SHALL hold NOP_INSTR constant and fetch entry struct {pc[31:0], instr[31:0]}.
REQ-035 Instruction FIFO SHALL be sub-module fetch_fifo (sync, DEPTH entries, push/pop/flush, count, full/empty).

Verification
REQ-036 Reset, IReqReady_i=1, 1-cycle responses -> addresses 0,4,8 issued consecutively; decode sees PCD_o 0,4,8 with ValidD_o=1.
REQ-037 IReqReady_i=0 for 5 cycles -> IReqAddr_o holds 0x0, no PC advance, ValidD_o=0 bubbles.
REQ-038 Two requests in flight (0x10,0x14), PCSrcE_i with target 0x100 -> both responses discarded, next decode PCD_o=0x100.
REQ-039 StallF_i=StallD_i=1 for 3 cycles with FIFO full -> IReqValid_o=0, decode outputs frozen; release -> order preserved.
REQ-040 PCSrcE_i=FlushD_i=1 with same-cycle response -> response dropped, ValidD_o=0, InstrD_o=32'h0000_0013.
REQ-041 PC=0xFFFF_FFFC fetched -> next IReqAddr_o=0x0000_0000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer of DEPTH entries with push, pop and flush.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               wdata,
    output fetch_entry_t               rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; flush empties the buffer in one edge.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= AW'(0);
            rptr  <= AW'(0);
            count <= (AW+1)'(0);
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == (AW+1)'(0));

endmodule

// File: rtl/fetch_unit_checker.sv
// Runtime checks on the fetch unit's credit accounting.
module fetch_unit_checker (
    input logic clk,
    input logic rst,
    input logic fifo_push,
    input logic fifo_full,
    input logic rsp_valid,
    input logic nothing_outstanding
);

    // The credit rule must keep the buffer from ever taking a push while full.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(fifo_push && fifo_full));
            assert (!(rsp_valid && nothing_outstanding));
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited request issue, in-order response tracking,
// redirect with stale-response draining, and the decode pipeline register.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF_i,
    input  logic        StallD_i,
    input  logic        FlushD_i,
    input  logic        PCSrcE_i,
    input  logic [31:0] PCTargetE_i,
    output logic        IReqValid_o,
    input  logic        IReqReady_i,
    output logic [31:0] IReqAddr_o,
    input  logic        IRspValid_i,
    input  logic [31:0] IRspData_i,
    output logic [31:0] InstrD_o,
    output logic [31:0] PCD_o,
    output logic [31:0] PCPlus4D_o,
    output logic        ValidD_o
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   pc;
    logic [AW:0]   inflight;
    logic [AW:0]   drop_cnt;
    logic [AW:0]   fifo_count;
    logic [AW+1:0] outstanding;
    logic [31:0]   pcq [DEPTH];
    logic [AW-1:0] pcq_wr;
    logic [AW-1:0] pcq_rd;
    logic          fifo_full;
    logic          fifo_empty;
    fetch_entry_t  fifo_head;
    fetch_entry_t  rsp_entry;
    logic          accept;
    logic          rsp_keep;
    logic          dec_load;
    logic          fifo_pop;
    logic          fifo_push;
    logic          bypass;

    // Everything requested but not yet handed to decode, including stale fetches.
    assign outstanding = (AW+2)'(inflight) + (AW+2)'(drop_cnt) + (AW+2)'(fifo_count);
    assign IReqValid_o = !rst && !StallF_i && !PCSrcE_i && (outstanding < (AW+2)'(DEPTH));
    assign IReqAddr_o  = pc;
    assign accept      = IReqValid_o && IReqReady_i;
    assign rsp_keep    = IRspValid_i && !PCSrcE_i && (drop_cnt == (AW+1)'(0));
    assign rsp_entry   = '{pc: pcq[pcq_rd], instr: IRspData_i};
    assign dec_load    = !StallD_i && !FlushD_i;
    assign fifo_pop    = dec_load && !fifo_empty;
    // An empty buffer lets a fresh response go straight to decode.
    assign bypass      = dec_load && fifo_empty && rsp_keep;
    assign fifo_push   = rsp_keep && !bypass;

    // In-flight PC queue storage.
    always_ff @(posedge clk) begin
        if (accept) begin
            pcq[pcq_wr] <= pc;
        end
    end

    // PC, in-flight accounting and redirect handling.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            inflight <= (AW+1)'(0);
            drop_cnt <= (AW+1)'(0);
            pcq_wr   <= AW'(0);
            pcq_rd   <= AW'(0);
        end else if (PCSrcE_i) begin
            pc       <= align_word(PCTargetE_i);
            inflight <= (AW+1)'(0);
            drop_cnt <= drop_cnt + inflight - (IRspValid_i ? (AW+1)'(1) : (AW+1)'(0));
            pcq_wr   <= AW'(0);
            pcq_rd   <= AW'(0);
        end else begin
            if (accept) begin
                pc     <= pc + 32'd4;
                pcq_wr <= pcq_wr + AW'(1);
            end
            if (rsp_keep) pcq_rd <= pcq_rd + AW'(1);
            case ({accept, rsp_keep})
                2'b10:   inflight <= inflight + (AW+1)'(1);
                2'b01:   inflight <= inflight - (AW+1)'(1);
                default: inflight <= inflight;
            endcase
            if (IRspValid_i && (drop_cnt != (AW+1)'(0))) begin
                drop_cnt <= drop_cnt - (AW+1)'(1);
            end else begin
                drop_cnt <= drop_cnt;
            end
        end
    end

    // Decode pipeline register; stall outranks flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            ValidD_o   <= 1'b0;
            InstrD_o   <= NOP_INSTR;
            PCD_o      <= 32'h0000_0000;
            PCPlus4D_o <= 32'h0000_0004;
        end else if (!StallD_i) begin
            if (FlushD_i) begin
                ValidD_o <= 1'b0;
                InstrD_o <= NOP_INSTR;
            end else if (fifo_pop) begin
                ValidD_o   <= 1'b1;
                InstrD_o   <= fifo_head.instr;
                PCD_o      <= fifo_head.pc;
                PCPlus4D_o <= fifo_head.pc + 32'd4;
            end else if (bypass) begin
                ValidD_o   <= 1'b1;
                InstrD_o   <= rsp_entry.instr;
                PCD_o      <= rsp_entry.pc;
                PCPlus4D_o <= rsp_entry.pc + 32'd4;
            end else begin
                ValidD_o <= 1'b0;
                InstrD_o <= NOP_INSTR;
            end
        end else begin
            ValidD_o <= ValidD_o;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (PCSrcE_i),
        .wdata (rsp_entry),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    fetch_unit_checker u_checker (
        .clk                 (clk),
        .rst                 (rst),
        .fifo_push           (fifo_push),
        .fifo_full           (fifo_full),
        .rsp_valid           (IRspValid_i),
        .nothing_outstanding ((inflight == (AW+1)'(0)) && (drop_cnt == (AW+1)'(0)))
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a memory with in-order variable latency and
// a queue-based model of program order, buffering and redirect epochs.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        StallF_i, StallD_i, FlushD_i, PCSrcE_i;
    logic [31:0] PCTargetE_i;
    logic        IReqValid_o, IReqReady_i;
    logic [31:0] IReqAddr_o;
    logic        IRspValid_i;
    logic [31:0] IRspData_i;
    logic [31:0] InstrD_o, PCD_o, PCPlus4D_o;
    logic        ValidD_o;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .StallF_i(StallF_i), .StallD_i(StallD_i), .FlushD_i(FlushD_i),
        .PCSrcE_i(PCSrcE_i), .PCTargetE_i(PCTargetE_i),
        .IReqValid_o(IReqValid_o), .IReqReady_i(IReqReady_i), .IReqAddr_o(IReqAddr_o),
        .IRspValid_i(IRspValid_i), .IRspData_i(IRspData_i),
        .InstrD_o(InstrD_o), .PCD_o(PCD_o), .PCPlus4D_o(PCPlus4D_o), .ValidD_o(ValidD_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    req_t        memq[$];
    ent_t        bufq[$];
    logic [31:0] m_pc;
    int          m_epoch;
    logic        d_valid;
    logic [31:0] d_pc, d_instr;
    int          cyc;
    int          total, bad;
    int          p_stallf, p_stalld, p_flush, p_redir, p_ready, dmax;
    logic        force_redir;
    logic [31:0] force_tgt;
    logic [31:0] seen_pcs[$];
    logic        record;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1234};
    endfunction

    task automatic model_reset();
        memq.delete();
        bufq.delete();
        m_pc    = 32'h0000_0000;
        m_epoch = 0;
        d_valid = 1'b0;
        d_pc    = 32'h0000_0000;
        d_instr = NOP_INSTR;
    endtask

    task automatic check_decode(input string tag);
        check({tag, "_validd"}, {31'd0, ValidD_o}, {31'd0, d_valid});
        if (d_valid) begin
            check({tag, "_pcd"}, PCD_o, d_pc);
            check({tag, "_pcp4"}, PCPlus4D_o, d_pc + 32'd4);
            check({tag, "_instr"}, InstrD_o, d_instr);
            if (record) seen_pcs.push_back(PCD_o);
        end else begin
            check({tag, "_nop"}, InstrD_o, NOP_INSTR);
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst = 1'b1;
        {StallF_i, StallD_i, FlushD_i, PCSrcE_i, IReqReady_i, IRspValid_i} = 6'b0;
        PCTargetE_i = 32'h0;
        IRspData_i  = 32'h0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_ireq_valid", {31'd0, IReqValid_o}, 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        model_reset();
        check("rst_validd", {31'd0, ValidD_o}, 32'd0);
        check("rst_instr", InstrD_o, NOP_INSTR);
        check("rst_pcd", PCD_o, 32'h0000_0000);
        check("rst_pcp4", PCPlus4D_o, 32'h0000_0004);
        check("rst_ireq_valid", {31'd0, IReqValid_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_first_addr", IReqAddr_o, 32'h0000_0000);
        cyc = 0;
    endtask

    task automatic run_cycles(input int n);
        logic        rsp, keep, consumed, pred;
        ent_t        e, h;
        req_t        r;
        logic [31:0] tgt;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rsp = (memq.size() > 0) && (memq[0].due <= cyc);
            StallF_i    = ($urandom_range(99) < p_stallf);
            StallD_i    = ($urandom_range(99) < p_stalld);
            PCSrcE_i    = force_redir || ($urandom_range(99) < p_redir);
            FlushD_i    = PCSrcE_i || ($urandom_range(99) < p_flush);
            IReqReady_i = ($urandom_range(99) < p_ready);
            case ($urandom_range(3))
                0:       tgt = 32'hFFFF_FFFC;
                1:       tgt = 32'h0000_0100;
                2:       tgt = $urandom | 32'h0000_0003;
                default: tgt = $urandom;
            endcase
            if (force_redir) tgt = force_tgt;
            force_redir = 1'b0;
            PCTargetE_i = tgt;
            IRspValid_i = rsp;
            IRspData_i  = rsp ? imem(memq[0].addr) : $urandom;

            @(negedge clk);
            check_decode("dec");
            pred = !StallF_i && !PCSrcE_i && ((memq.size() + bufq.size()) < DEPTH);
            check("ireq_valid", {31'd0, IReqValid_o}, {31'd0, pred});
            if (pred) check("ireq_addr", IReqAddr_o, m_pc);

            keep = rsp && !PCSrcE_i && (memq[0].epoch == m_epoch);
            if (rsp) begin
                e.pc    = memq[0].addr;
                e.instr = imem(memq[0].addr);
                void'(memq.pop_front());
            end
            consumed = 1'b0;
            if (!StallD_i) begin
                if (FlushD_i) begin
                    d_valid = 1'b0;
                    d_instr = NOP_INSTR;
                end else if (bufq.size() > 0) begin
                    h = bufq.pop_front();
                    d_valid = 1'b1; d_pc = h.pc; d_instr = h.instr;
                end else if (keep) begin
                    d_valid = 1'b1; d_pc = e.pc; d_instr = e.instr;
                    consumed = 1'b1;
                end else begin
                    d_valid = 1'b0;
                    d_instr = NOP_INSTR;
                end
            end
            if (keep && !consumed) bufq.push_back(e);
            if (pred && IReqReady_i) begin
                r.addr  = m_pc;
                r.epoch = m_epoch;
                r.due   = cyc + $urandom_range(dmax, 1);
                memq.push_back(r);
                m_pc = m_pc + 32'd4;
            end
            if (PCSrcE_i) begin
                bufq.delete();
                m_epoch++;
                m_pc = {tgt[31:2], 2'b00};
            end
            cyc++;
        end
    endtask

    task automatic set_mode(input int sf, input int sd, input int fl, input int rd,
                            input int rdy, input int dm);
        p_stallf = sf; p_stalld = sd; p_flush = fl; p_redir = rd; p_ready = rdy; dmax = dm;
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        force_redir = 1'b0; force_tgt = 32'h0; record = 1'b0;
        rst = 1'b1;
        {StallF_i, StallD_i, FlushD_i, PCSrcE_i, IReqReady_i, IRspValid_i} = 6'b0;
        PCTargetE_i = 32'h0; IRspData_i = 32'h0;
        model_reset();

        do_reset(3);
        // Streaming with always-ready memory and one-cycle responses.
        set_mode(0, 0, 0, 0, 100, 1);
        record = 1'b1;
        run_cycles(12);
        record = 1'b0;
        if (seen_pcs.size() >= 3) begin
            check("stream_pc0", seen_pcs[0], 32'h0000_0000);
            check("stream_pc1", seen_pcs[1], 32'h0000_0004);
            check("stream_pc2", seen_pcs[2], 32'h0000_0008);
        end else begin
            check("stream_count", seen_pcs.size(), 32'd3);
        end

        // Memory not ready right after reset: address must hold at 0.
        do_reset(2);
        set_mode(0, 0, 0, 0, 0, 1);
        run_cycles(5);
        check("notready_addr", IReqAddr_o, 32'h0000_0000);

        // Redirect to the top word, then follow the wrap to zero.
        set_mode(0, 0, 0, 0, 100, 2);
        force_redir = 1'b1;
        force_tgt   = 32'hFFFF_FFFC;
        run_cycles(8);

        set_mode(20, 20, 10, 5, 70, 3);
        run_cycles(2000);
        set_mode(60, 60, 5, 3, 80, 2);
        run_cycles(1500);
        do_reset(2);
        set_mode(15, 25, 10, 15, 60, 3);
        run_cycles(2000);
        set_mode(0, 0, 0, 10, 100, 1);
        run_cycles(500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
